// File: rtl/tdm_mux_4to1_pkg.sv
// Shared constants and the channel-index type for the 4-channel TDM mux.
package tdm_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/tdm_mux_4to1_arb.sv
// Combinational 4-way round-robin arbiter: search starts one past the last
// granted channel and wraps, so the last winner has the lowest priority.
module rr_arbiter_4
    import tdm_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    input  sel_t              last,
    output logic [NUM_CH-1:0] gnt,
    output sel_t              gnt_idx,
    output logic              gnt_vld
);
    sel_t cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = last;
        gnt_vld = 1'b0;
        cand    = last;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = sel_t'(int'(last) + k);
            if (en && !gnt_vld && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_vld   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tdm_mux_4to1.sv
// Four-channel round-robin TDM merger with registered output beat and
// source index, valid/ready on every side.
module tdm_mux_4to1
    import tdm_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output sel_t                     out_sel,
    input  logic                     out_ready
);
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    sel_t              out_sel_q, out_sel_d;
    sel_t              last_q, last_d;

    logic              load;
    logic [NUM_CH-1:0] gnt;
    sel_t              gnt_idx;
    logic              gnt_vld;

    assign load = !out_valid_q || out_ready;

    // Gating with rst_n keeps in_ready low for every cycle reset is held.
    rr_arbiter_4 u_arb (
        .req     (in_valid),
        .en      (load && rst_n),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign in_ready = gnt;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = in_data[gnt_idx*DATA_W +: DATA_W];
                out_sel_d  = gnt_idx;
                last_d     = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            last_q      <= sel_t'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
endmodule
